// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift-chain sequencer.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FILL  = 2'b01,
      RUN   = 2'b10,
      DRAIN = 2'b11
   } state_t;

   localparam int DEF_DEPTH    = 3;
   localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/shift_chain_sequencer_tick_gen.sv
// Prescale counter: counts 0..PRESCALE-1 while enabled, asserts tick on the
// last count. clear returns the count to zero and wins over counting.
module tick_gen
   import shift_seq_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int CNT_W    = $clog2(PRESCALE) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tick
);

   logic [CNT_W-1:0] cnt;
   logic             at_end;

   assign at_end = (cnt == CNT_W'(PRESCALE - 1));
   assign tick   = en && at_end;

   // Prescale count, wrapping at PRESCALE-1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_end ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/shift_chain_sequencer.sv
// Fill/run/drain sequencer for a DEPTH-stage shift chain sampled on
// prescaled ticks. Build option: define TICK_BYPASS_EN to tick every cycle
// (no prescale counter; latencies become DEPTH cycles).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; chain holds whatever drain left (zeros)
// FILL  | shifting real samples in; taps not yet all meaningful
// RUN   | chain full of real samples; valid high
// DRAIN | shifting zeros in; done pulses after DEPTH ticks
module shift_chain_sequencer
   import shift_seq_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int CNT_W    = $clog2((PRESCALE > DEPTH) ? PRESCALE : DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             sig_in,
   output logic [DEPTH-1:0] taps,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_FILL  = 2'(FILL);
   localparam logic [1:0] S_RUN   = 2'(RUN);
   localparam logic [1:0] S_DRAIN = 2'(DRAIN);

   logic [1:0]       state;
   logic [CNT_W-1:0] stage;
   logic             tick;
   logic             shift_in;
   logic             stop_req;
   logic             last_stage;

   assign stop_req   = stop && ((state == S_FILL) || (state == S_RUN));
   assign shift_in   = (state == S_DRAIN) ? 1'b0 : sig_in;
   assign last_stage = (stage == CNT_W'(DEPTH - 1));

`ifdef TICK_BYPASS_EN
   assign tick = 1'b1;
`else
   // Counter restarts on entry to FILL and to DRAIN so both latencies are
   // exactly DEPTH*PRESCALE regardless of where the stop landed.
   tick_gen #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (!busy || stop_req),
      .en    (busy),
      .tick  (tick)
   );
`endif

   // Sequencing FSM with stage counter and status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         stage <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FILL;
                  stage <= '0;
                  busy  <= 1'b1;
               end
            end
            S_FILL: begin
               if (stop) begin
                  state <= S_DRAIN;
                  stage <= '0;
               end else if (tick) begin
                  if (last_stage) begin
                     state <= S_RUN;
                     stage <= '0;
                     valid <= 1'b1;
                  end else begin
                     stage <= stage + CNT_W'(1);
                  end
               end
            end
            S_RUN: begin
               if (stop) begin
                  state <= S_DRAIN;
                  stage <= '0;
                  valid <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (tick) begin
                  if (last_stage) begin
                     state <= S_IDLE;
                     stage <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     stage <= stage + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               stage <= '0;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Chain: cleared on start, shifts on every tick while busy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         taps <= '0;
      end else if ((state == S_IDLE) && start) begin
         taps <= '0;
      end else if ((state != S_IDLE) && tick) begin
         taps <= {taps[DEPTH-2:0], shift_in};
      end
   end

endmodule

// File: tb/tb_shift_chain_sequencer.sv
module tb_shift_chain_sequencer;

   localparam int DEPTH    = 3;
   localparam int PRESCALE = 4;
`ifdef TICK_BYPASS_EN
   localparam int P_EFF = 1;
`else
   localparam int P_EFF = PRESCALE;
`endif
   localparam int LAT = DEPTH * P_EFF;

   logic             clk = 1'b0;
   logic             rst_n, start, stop, sig_in;
   logic [DEPTH-1:0] taps;
   logic             valid, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: phase by elapsed edges since entering a mode
   int m_mode;   // 0 idle, 1 fill, 2 run, 3 drain
   int m_k;
   bit m_q[$];
   bit m_valid, m_busy, m_done;

   shift_chain_sequencer #(.DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .stop   (stop),
      .sig_in (sig_in),
      .taps   (taps),
      .valid  (valid),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DEPTH-1:0] m_taps();
      logic [DEPTH-1:0] r;
      for (int i = 0; i < DEPTH; i++) r[i] = m_q[i];
      return r;
   endfunction

   task automatic m_clear_chain();
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) m_q.push_back(1'b0);
   endtask

   task automatic m_shift(input bit b);
      m_q.push_front(b);
      void'(m_q.pop_back());
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         m_mode = 0; m_k = 0; m_valid = 0; m_busy = 0; m_done = 0;
         m_clear_chain();
      end else begin
         m_done = 0;
         case (m_mode)
            0: if (start) begin
               m_mode = 1; m_k = 0; m_busy = 1;
               m_clear_chain();
            end
            1, 2: begin
               m_k++;
               if (m_k % P_EFF == 0) m_shift(sig_in);
               if (stop) begin
                  m_mode = 3; m_k = 0; m_valid = 0;
               end else if (m_mode == 1 && m_k == LAT) begin
                  m_mode = 2; m_valid = 1;
               end
            end
            default: begin
               m_k++;
               if (m_k % P_EFF == 0) m_shift(1'b0);
               if (m_k == LAT) begin
                  m_mode = 0; m_busy = 0; m_done = 1;
               end
            end
         endcase
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic p, input logic d);
      @(negedge clk);
      rst_n = r; start = s; stop = p; sig_in = d;
      @(posedge clk);
      model_edge();
      #1;
      chk("taps", 32'(taps), 32'(m_taps()));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
   endtask

   initial begin
      int n;
      bit saw_valid;
      logic [2:0] pat;
      pat = 3'b101;
      rst_n = 0; start = 0; stop = 0; sig_in = 0;
      m_clear_chain();

      // reset
      cycle(0, 0, 0, 0);
      cycle(0, 1, 1, 1);
      chk("rst_taps", 32'(taps), 0);
      chk("rst_busy", 32'(busy), 0);

      // fill ordering and start-to-valid latency
      cycle(1, 1, 0, 0);
      for (int k = 1; k <= LAT; k++) cycle(1, 0, 0, pat[(k - 1) / P_EFF]);
      chk("fill_taps", 32'(taps), 32'(3'b101));
      chk("fill_valid", 32'(valid), 1);

      // start while running is ignored
      for (int k = 0; k < 5; k++) cycle(1, 1, 0, 1'(k));

      // stop in RUN, measure drain latency
      cycle(1, 0, 1, 1);
      chk("stop_valid_fall", 32'(valid), 0);
      n = 0;
      while (!done && n < 200) begin cycle(1, 0, 0, 1); n++; end
      chk("drain_latency", 32'(n), 32'(LAT));
      chk("drain_taps", 32'(taps), 0);
      cycle(1, 0, 0, 1);
      chk("done_single", 32'(done), 0);

      // stop in IDLE ignored
      for (int k = 0; k < 4; k++) cycle(1, 0, 1, 1);
      chk("idle_stop_busy", 32'(busy), 0);

      // start-to-valid latency with random data
      cycle(1, 1, 1, 1);
      n = 0;
      while (!valid && n < 200) begin cycle(1, 0, 0, 1'($urandom)); n++; end
      chk("valid_latency", 32'(n), 32'(LAT));

      // reset mid-RUN
      cycle(0, 0, 0, 1);
      chk("midrun_rst_taps", 32'(taps), 0);
      chk("midrun_rst_valid", 32'(valid), 0);
      chk("midrun_rst_busy", 32'(busy), 0);

      // early stop after the first tick of FILL
      cycle(1, 1, 0, 1);
      for (int k = 0; k < P_EFF; k++) cycle(1, 0, 0, 1);
      cycle(1, 0, 1, 1);
      n = 0; saw_valid = 0;
      while (!done && n < 200) begin
         cycle(1, 0, 0, 1); n++;
         if (valid) saw_valid = 1;
      end
      chk("early_latency", 32'(n), 32'(LAT));
      chk("early_no_valid", 32'(saw_valid), 0);

      // randomized traffic against the model
      for (int k = 0; k < 4000; k++)
         cycle(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 7) == 0),
               logic'($urandom_range(0, 24) == 0), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_chain_sequencer.md
Name: shift_chain_sequencer

Overview:
Sequences a DEPTH-stage nonblocking shift chain: the registered form of the Sig→D→E→F chain.
- Samples sig_in into the chain only on prescaled shift ticks.
- Controls when the chain fills, runs and drains, and reports when tap contents are meaningful.
- Sits between a slow external signal source and downstream logic that reads the tap vector.

Parameters:
DEPTH, 3, number of chain stages (taps); minimum 2.
PRESCALE, 4, clock cycles per shift tick; minimum 1.
CNT_W, $clog2(PRESCALE>DEPTH?PRESCALE:DEPTH)+1, width of internal tick and stage counters.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  reset.
start  input  1  request to begin a fill/run sequence; sampled only in IDLE.
stop  input  1  request to end sequence; sampled only in FILL or RUN.
sig_in  input  1  serial signal shifted into taps[0] on each tick.
taps  output  DEPTH  chain contents; taps[0] newest sample, taps[DEPTH-1] oldest.
valid  output  1  high while chain fully filled with real samples (RUN only).
busy  output  1  high in FILL, RUN, DRAIN.
done  output  1  single-cycle pulse on DRAIN→IDLE transition.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset is synchronous and active-low (rst_n).
- Reset state: state=IDLE; taps=0; valid=0; busy=0; done=0; all counters 0. Applies on the next clk edge with rst_n=0, including mid-sequence. There is no partial drain.
- Tick generator:
  - Counter is cleared on entry to FILL.
  - Counts 0..PRESCALE-1 while busy, then wraps.
  - tick=1 in the cycle where count==PRESCALE-1; the shift occurs on that edge.
  - PRESCALE=1 gives a tick every cycle.
- Shift on tick: taps[0]<=shift_in; taps[i]<=taps[i-1]. shift_in=sig_in in FILL/RUN and 0 in DRAIN. Taps hold between ticks.
- IDLE:
  - start=1 → FILL; taps cleared to 0; stage counter=0.
  - stop is ignored. start+stop together → FILL.
- FILL:
  - Each tick increments the stage counter.
  - On the DEPTH-th tick edge → RUN; valid rises in the same edge.
  - stop=1 (any cycle, including a tick cycle) → DRAIN. The tick shift still occurs; valid is never asserted.
- RUN:
  - valid=1; shifts on every tick.
  - stop=1 → DRAIN at that edge. valid falls the same edge; a coincident tick shift still occurs.
- DRAIN:
  - Stage counter cleared on entry; zeros are shifted on each tick.
  - On the DEPTH-th tick edge → IDLE with done=1 for exactly one cycle. taps are then 0.
- start while busy is ignored (no queueing). stop in DRAIN is ignored.
- busy = (state != IDLE), registered.
- Latency: start edge to valid = DEPTH*PRESCALE cycles. stop edge to done = DEPTH*PRESCALE cycles.

Optional Feature:
TICK_BYPASS_EN
- Defined: tick is forced to 1 every cycle regardless of PRESCALE. The tick counter is not instantiated; latencies become DEPTH cycles.
- Undefined: prescaled behaviour as specified above.

Decomposition:
- Package shift_seq_pkg:
  - state typedef enum {IDLE, FILL, RUN, DRAIN}, 2-bit encoding 00/01/10/11.
  - default DEPTH and PRESCALE constants.
- Sub-module tick_gen: prescale counter with clear input and tick output, parameterised by PRESCALE. Bypassed when TICK_BYPASS_EN is defined.

Test Plan:
1. Reset mid-RUN: DEPTH=3, PRESCALE=4, drive rst_n=0 one cycle while valid=1 → next edge taps=000, valid=0, busy=0, state IDLE.
2. Fill ordering: start at edge 0, sig_in=1,0,1 at ticks (edges 4,8,12) → valid rises at edge 12, taps=3'b101.
3. Run/drain: in RUN assert stop one cycle → valid falls that edge, taps shift in zeros at the next 3 ticks, done pulses one cycle 12 cycles after the stop edge, taps=000.
4. Early stop in FILL: stop after the 1st tick → DRAIN, valid never 1, done after 3 further ticks.
5. Ignored requests: start during RUN and stop during IDLE → no state change, no done.
6. TICK_BYPASS_EN defined: start, sig_in=1 constant → valid after 3 cycles with taps=111; stop → done 3 cycles later.
